// File: rtl/mylogic_pkg.sv
// Shared constants for the mylogic table-lookup block: default truth tables,
// index width, and the one-hot helper used for minterm coverage tracking.
package mylogic_pkg;

  localparam int IDX_W   = 3;
  localparam int TABLE_W = 1 << IDX_W;

  localparam logic [TABLE_W-1:0] MAJ3_TABLE = 8'hE8;
  localparam logic [TABLE_W-1:0] XOR3_TABLE = 8'h96;

  function automatic logic [TABLE_W-1:0] onehot_idx(input logic [IDX_W-1:0] idx);
    return TABLE_W'(1) << idx;
  endfunction

endpackage

// File: rtl/mylogic_lut3.sv
// Purely combinational 8-entry truth-table lookup; the bit of TABLE selected
// by idx is the result. No state lives here.
module lut3
  import mylogic_pkg::*;
#(
  parameter logic [TABLE_W-1:0] TABLE = MAJ3_TABLE
) (
  input  logic [IDX_W-1:0] idx,
  output logic             o
);

  assign o = TABLE[idx];

endmodule

// File: rtl/mylogic.sv
// Registered 3-input truth-table evaluator with sticky minterm coverage.
// x/y are one-cycle-latency lookups of {A,B,C}; all flops live here.
module mylogic
  import mylogic_pkg::*;
#(
  parameter logic [TABLE_W-1:0] X_TABLE = MAJ3_TABLE,
  parameter logic [TABLE_W-1:0] Y_TABLE = XOR3_TABLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               A,
  input  logic               B,
  input  logic               C,
  output logic               x,
  output logic               y,
  output logic               out_valid,
  output logic [TABLE_W-1:0] minterm_seen,
  output logic               all_seen
);

  logic [IDX_W-1:0]   idx;
  logic               x_lut, y_lut;

  logic               x_q, x_d;
  logic               y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic [TABLE_W-1:0] minterm_seen_q, minterm_seen_d;
  logic               all_seen_q, all_seen_d;

  assign idx = {A, B, C};

  lut3 #(.TABLE(X_TABLE)) u_lut_x (
    .idx (idx),
    .o   (x_lut)
  );

  lut3 #(.TABLE(Y_TABLE)) u_lut_y (
    .idx (idx),
    .o   (y_lut)
  );

  // all_seen looks at the coverage including this edge's index so it rises
  // on the same edge that records the last missing combination.
  always_comb begin
    x_d            = x_lut;
    y_d            = y_lut;
    out_valid_d    = 1'b1;
    minterm_seen_d = minterm_seen_q | onehot_idx(idx);
    all_seen_d     = all_seen_q | (&minterm_seen_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= 1'b0;
      y_q            <= 1'b0;
      out_valid_q    <= 1'b0;
      minterm_seen_q <= '0;
      all_seen_q     <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      out_valid_q    <= out_valid_d;
      minterm_seen_q <= minterm_seen_d;
      all_seen_q     <= all_seen_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign out_valid    = out_valid_q;
  assign minterm_seen = minterm_seen_q;
  assign all_seen     = all_seen_q;

endmodule

// File: tb/tb_mylogic.sv
// Directed bench for mylogic: default-table instance plus a second instance
// with custom tables, both fed from the same clock, reset and operands.
module tb_mylogic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       A = 1'b0, B = 1'b0, C = 1'b0;

  logic       x, y, out_valid, all_seen;
  logic [7:0] minterm_seen;
  logic       x2, y2, out_valid2, all_seen2;
  logic [7:0] minterm_seen2;

  int n_vec = 0;
  int n_err = 0;

  // Hand-derived: majority is 1 for idx 3,5,6,7; XOR3 is 1 for idx 1,2,4,7.
  bit x_seq [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
  bit y_seq [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

  always #5 clk = ~clk;

  mylogic dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .C            (C),
    .x            (x),
    .y            (y),
    .out_valid    (out_valid),
    .minterm_seen (minterm_seen),
    .all_seen     (all_seen)
  );

  mylogic #(.X_TABLE(8'h01), .Y_TABLE(8'h80)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .C            (C),
    .x            (x2),
    .y            (y2),
    .out_valid    (out_valid2),
    .minterm_seen (minterm_seen2),
    .all_seen     (all_seen2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {A, B, C} = 3'b000;
    tick();
    tick();
    n_vec++;
    if ({x, y, out_valid, all_seen, minterm_seen} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_hold: got x=%b y=%b ov=%b as=%b ms=%h, want all 0",
               x, y, out_valid, all_seen, minterm_seen);
    end
    rst = 1'b0;
    #2;
    n_vec++;
    if ({x, y, out_valid, all_seen, minterm_seen} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_release_pre_edge: got x=%b y=%b ov=%b as=%b ms=%h, want all 0",
               x, y, out_valid, all_seen, minterm_seen);
    end
    tick();
    n_vec++;
    if (x !== 1'b0 || y !== 1'b0 || out_valid !== 1'b1 || minterm_seen !== 8'h01 || all_seen !== 1'b0) begin
      n_err++;
      $display("FAIL first_edge: got x=%b y=%b ov=%b ms=%h as=%b, want x=0 y=0 ov=1 ms=01 as=0",
               x, y, out_valid, minterm_seen, all_seen);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_ms;
    bit         prev_x, prev_y;
    do_reset();
    exp_ms = 8'h00;
    prev_x = 1'b0;
    prev_y = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {A, B, C} = 3'(i);
      #1;
      n_vec++;
      if (x !== prev_x || y !== prev_y) begin
        n_err++;
        $display("FAIL sweep_no_comb_path idx=%0d: got x=%b y=%b, want x=%b y=%b",
                 i, x, y, prev_x, prev_y);
      end
      tick();
      exp_ms = exp_ms | (8'h01 << i);
      n_vec++;
      if (x !== x_seq[i] || y !== y_seq[i]) begin
        n_err++;
        $display("FAIL sweep_xy idx=%0d: got x=%b y=%b, want x=%b y=%b",
                 i, x, y, x_seq[i], y_seq[i]);
      end
      n_vec++;
      if (minterm_seen !== exp_ms || all_seen !== (i == 7) || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL sweep_cov idx=%0d: got ms=%h as=%b ov=%b, want ms=%h as=%b ov=1",
                 i, minterm_seen, all_seen, out_valid, exp_ms, (i == 7));
      end
      n_vec++;
      if (x2 !== (i == 0) || y2 !== (i == 7)) begin
        n_err++;
        $display("FAIL custom_tables idx=%0d: got x=%b y=%b, want x=%b y=%b",
                 i, x2, y2, (i == 0), (i == 7));
      end
      repeat (9) tick();
      n_vec++;
      if (x !== x_seq[i] || y !== y_seq[i] || minterm_seen !== exp_ms) begin
        n_err++;
        $display("FAIL sweep_hold idx=%0d: got x=%b y=%b ms=%h, want x=%b y=%b ms=%h",
                 i, x, y, minterm_seen, x_seq[i], y_seq[i], exp_ms);
      end
      prev_x = x_seq[i];
      prev_y = y_seq[i];
    end
    {A, B, C} = 3'b011;
    repeat (3) tick();
    n_vec++;
    if (all_seen !== 1'b1 || minterm_seen !== 8'hFF || x !== 1'b1 || y !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_after_sweep: got as=%b ms=%h x=%b y=%b, want as=1 ms=ff x=1 y=0",
               all_seen, minterm_seen, x, y);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {A, B, C} = 3'(i);
      tick();
    end
    n_vec++;
    if (minterm_seen !== 8'h1F) begin
      n_err++;
      $display("FAIL mid_sweep_cov: got ms=%h, want ms=1f", minterm_seen);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({x, y, out_valid, all_seen, minterm_seen} !== 12'h000) begin
      n_err++;
      $display("FAIL mid_reset_clear: got x=%b y=%b ov=%b as=%b ms=%h, want all 0",
               x, y, out_valid, all_seen, minterm_seen);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (minterm_seen !== 8'h10 || out_valid !== 1'b1 || x !== 1'b0 || y !== 1'b1 || all_seen !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_restart: got ms=%h ov=%b x=%b y=%b as=%b, want ms=10 ov=1 x=0 y=1 as=0",
               minterm_seen, out_valid, x, y, all_seen);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    {A, B, C} = 3'b110;
    tick();
    n_vec++;
    if (x !== 1'b1 || minterm_seen !== 8'h40) begin
      n_err++;
      $display("FAIL prio_setup: got x=%b ms=%h, want x=1 ms=40", x, minterm_seen);
    end
    rst = 1'b1;
    {A, B, C} = 3'b111;
    tick();
    n_vec++;
    if ({x, y, out_valid, all_seen, minterm_seen} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_priority: got x=%b y=%b ov=%b as=%b ms=%h, want all 0",
               x, y, out_valid, all_seen, minterm_seen);
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    {A, B, C} = 3'b101;
    repeat (20) tick();
    n_vec++;
    if (x !== 1'b1 || y !== 1'b0 || minterm_seen !== 8'h20 || all_seen !== 1'b0) begin
      n_err++;
      $display("FAIL hold_one_combo: got x=%b y=%b ms=%h as=%b, want x=1 y=0 ms=20 as=0",
               x, y, minterm_seen, all_seen);
    end
    n_vec++;
    if (x2 !== 1'b0 || y2 !== 1'b0 || minterm_seen2 !== 8'h20) begin
      n_err++;
      $display("FAIL hold_custom: got x=%b y=%b ms=%h, want x=0 y=0 ms=20",
               x2, y2, minterm_seen2);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mid_reset();
    test_reset_priority();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mylogic.md
MYLOGIC -- requirements
Module: mylogic

Interface
REQ-001 SHALL have parameter X_TABLE, default 8'hE8: truth table for x, indexed by {A,B,C} (3-input majority).
REQ-002 SHALL have parameter Y_TABLE, default 8'h96: truth table for y, indexed by {A,B,C} (3-input XOR).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port A, input, 1 bit: operand, MSB of the table index.
REQ-006 SHALL have port B, input, 1 bit: operand, middle bit of the table index.
REQ-007 SHALL have port C, input, 1 bit: operand, LSB of the table index.
REQ-008 SHALL have port x, output, 1 bit: registered X_TABLE lookup.
REQ-009 SHALL have port y, output, 1 bit: registered Y_TABLE lookup.
REQ-010 SHALL have port out_valid, output, 1 bit: x and y hold a result computed from inputs sampled since reset.
REQ-011 SHALL have port minterm_seen, output, 8 bits: sticky per-index record of applied input combinations.
REQ-012 SHALL have port all_seen, output, 1 bit: all 8 combinations applied since reset.

Function
REQ-013 Index idx SHALL equal {A,B,C}, 0..7; inputs SHALL be sampled every rising clk edge, with no enable.
REQ-014 On each edge with rst=0, x SHALL load X_TABLE[idx] and y SHALL load Y_TABLE[idx]: latency exactly 1 cycle, no combinational input-to-output path.
REQ-015 With defaults, x SHALL be 1 for idx 3,5,6,7 and y SHALL be 1 for idx 1,2,4,7.
REQ-016 out_valid SHALL go 1 on the first edge with rst=0 and stay 1 until the next reset.
REQ-017 On each edge with rst=0, minterm_seen[idx] SHALL be set to 1; set bits SHALL never clear except by reset.
REQ-018 all_seen SHALL be registered as the AND of all bits of (minterm_seen OR onehot(idx)), so it rises on the same edge the last missing combination is recorded.
REQ-019 all_seen SHALL be sticky until reset.
REQ-020 Holding one combination for many cycles SHALL give stable outputs and SHALL NOT change any other minterm_seen bit.
REQ-021 X or Z on A, B or C is out of scope; no defined behaviour is required.

Reset
REQ-022 When rst=1 at a rising edge, x, y, out_valid and all_seen SHALL become 0 and minterm_seen SHALL become 8'h00.
REQ-023 Reset SHALL take priority over input sampling on the same edge.
REQ-024 Reset asserted mid-sweep SHALL discard all coverage history.
REQ-025 The first edge after reset deasserts SHALL behave as a normal sampling edge.

Structure
REQ-026 Package mylogic_pkg SHALL hold the default table constants (MAJ3_TABLE=8'hE8, XOR3_TABLE=8'h96) and the index width constant (3).
REQ-027 Sub-module lut3 (8-entry combinational table lookup: parameter TABLE, 3-bit index in, 1-bit out) SHALL be instantiated twice, once for x and once for y.
REQ-028 All flops SHALL reside in mylogic.

Verification
REQ-029 Hold rst=1 for 2 cycles, then rst=0 with ABC=000 -> before the edge everything is 0; after one edge x=0, y=0, out_valid=1, minterm_seen=8'h01.
REQ-030 Sweep ABC 000..111, each held 10 cycles -> x sequence 0,0,0,1,0,1,1,1; y sequence 0,1,1,0,1,0,0,1, each one cycle after the input change.
REQ-031 Same sweep -> all_seen rises on the first edge sampling ABC=111 and minterm_seen=8'hFF.
REQ-032 Apply 000..100, assert rst for 1 cycle, release -> all outputs 0 during reset; minterm_seen restarts from only the current idx bit.
REQ-033 Instantiate with X_TABLE=8'h01, Y_TABLE=8'h80 and sweep -> x=1 only for ABC=000; y=1 only for ABC=111.
REQ-034 Change ABC on the same edge rst is asserted -> outputs stay 0 and minterm_seen stays 8'h00.
